// File: rtl/resp_compactor_pkg.sv
// -----------------------------------------------------------------------------
// resp_compactor_pkg
//   Shared types and constants for the response compactor:
//   - state_t      : run-control FSM states
//   - DEFAULT_POLY : default MISR feedback polynomial (MSB-out, CRC-32 taps)
// -----------------------------------------------------------------------------
package resp_compactor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [31:0] DEFAULT_POLY = 32'h04C11DB7;

endpackage : resp_compactor_pkg

// File: rtl/resp_misr.sv
// -----------------------------------------------------------------------------
// resp_misr
//   SIG_W-bit multiple-input signature register, MSB-out feedback.
//   Ports:
//     ck       in  clock, rising edge
//     rst      in  asynchronous active-high reset (register -> SEED)
//     load     in  reload SEED (has priority over en)
//     en       in  absorb data this cycle
//     data     in  SIG_W  vector to fold in (already masked / zero-extended)
//     sig      out SIG_W  current signature
//     sig_next out SIG_W  signature after absorbing data (used for compare)
// -----------------------------------------------------------------------------
module resp_misr #(
  parameter int unsigned          SIG_W = 32,
  parameter logic [SIG_W-1:0]     POLY  = resp_compactor_pkg::DEFAULT_POLY,
  parameter logic [SIG_W-1:0]     SEED  = '0
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [SIG_W-1:0] data,
  output logic [SIG_W-1:0] sig,
  output logic [SIG_W-1:0] sig_next
);

  logic [SIG_W-1:0] sig_q;

  assign sig_next = {sig_q[SIG_W-2:0], 1'b0}
                  ^ (sig_q[SIG_W-1] ? POLY : '0)
                  ^ data;
  assign sig      = sig_q;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; the async reset sits in the sensitivity list.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      sig_q <= SEED;
    end else if (load) begin
      sig_q <= SEED;
    end else if (en) begin
      sig_q <= sig_next;
    end
  end

endmodule : resp_misr

// File: rtl/resp_compactor.sv
// -----------------------------------------------------------------------------
// resp_compactor
//   Compacts the per-cycle output vector of a circuit under test into a MISR
//   signature, counts accepted vectors and, after LEN vectors, compares the
//   signature against an expected value.
//   Ports:
//     ck        in   clock, rising edge
//     rst       in   asynchronous active-high reset
//     mask      in   WIDTH  (only with RESP_COMPACTOR_MASK_EN) 1 = exclude bit
//     start     in   one-cycle pulse, begins a run from IDLE or DONE
//     len       in   CNT_W  vectors to compact, sampled on start
//     exp_sig   in   SIG_W  expected signature, sampled on start
//     in_valid  in   in_data valid
//     in_data   in   WIDTH  vector from circuit under test
//     in_ready  out  vector accepted this cycle (state == RUN)
//     busy      out  state == RUN
//     done      out  state == DONE, held until next start
//     pass      out  registered signature compare, valid while done
//     sig       out  SIG_W  current signature
//     count     out  CNT_W  vectors accepted in current run
//   Configuration macro: RESP_COMPACTOR_MASK_EN adds the mask port; mask is
//   sampled on start and held for the run.
// -----------------------------------------------------------------------------
module resp_compactor
  import resp_compactor_pkg::*;
#(
  parameter int unsigned      WIDTH = 19,
  parameter int unsigned      SIG_W = 32,
  parameter int unsigned      CNT_W = 16,
  parameter logic [SIG_W-1:0] POLY  = DEFAULT_POLY,
  parameter logic [SIG_W-1:0] SEED  = '0
) (
  input  logic             ck,
  input  logic             rst,
`ifdef RESP_COMPACTOR_MASK_EN
  input  logic [WIDTH-1:0] mask,
`endif
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic [SIG_W-1:0] exp_sig,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] sig,
  output logic [CNT_W-1:0] count
);

  state_t           state;
  logic [CNT_W-1:0] len_q;
  logic [SIG_W-1:0] exp_q;
  logic [WIDTH-1:0] mask_q;
  logic [SIG_W-1:0] data_ext;
  logic [SIG_W-1:0] sig_next;
  logic [CNT_W-1:0] last_idx;
  logic             beat;
  logic             take_start;

  assign in_ready   = (state == ST_RUN);
  assign busy       = (state == ST_RUN);
  assign done       = (state == ST_DONE);
  assign beat       = in_valid & in_ready;
  assign take_start = start & (state != ST_RUN);
  assign last_idx   = len_q - 1'b1;

`ifndef RESP_COMPACTOR_MASK_EN
  // Without the mask feature every output bit is compacted.
  logic [WIDTH-1:0] mask;
  assign mask = '0;
`endif

  // NOTE: every signal driven in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    data_ext              = '0;
    data_ext[WIDTH-1:0]   = in_data & ~mask_q;
  end

  resp_misr #(
    .SIG_W (SIG_W),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr (
    .ck       (ck),
    .rst      (rst),
    .load     (take_start),
    .en       (beat),
    .data     (data_ext),
    .sig      (sig),
    .sig_next (sig_next)
  );

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      count  <= '0;
      len_q  <= '0;
      exp_q  <= '0;
      mask_q <= '0;
      pass   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            len_q  <= len;
            exp_q  <= exp_sig;
            mask_q <= mask;
            count  <= '0;
            if (len == '0) begin
              // Empty run: the final signature is SEED itself.
              state <= ST_DONE;
              pass  <= (SEED == exp_sig);
            end else begin
              state <= ST_RUN;
              pass  <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          if (beat) begin
            count <= count + 1'b1;
            if (count == last_idx) begin
              // Compare against the signature this beat produces so pass is
              // already valid in the first DONE cycle.
              state <= ST_DONE;
              pass  <= (sig_next == exp_q);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule : resp_compactor

// File: tb/tb_resp_compactor.sv
// -----------------------------------------------------------------------------
// tb_resp_compactor
//   Randomized, scoreboarded bench for resp_compactor. Each run's expected
//   final signature / count / pass is computed from the vector list with a
//   plain software MISR and queued; a monitor pops it when the DUT enters DONE.
// -----------------------------------------------------------------------------
module tb_resp_compactor;

  localparam int unsigned WIDTH = 19;
  localparam int unsigned SIG_W = 32;
  localparam int unsigned CNT_W = 16;
  localparam logic [31:0] POLY  = 32'h04C11DB7;
  localparam logic [31:0] SEED  = 32'h00000000;

  typedef struct {
    logic [31:0] sig;
    logic [15:0] count;
    logic        pass;
  } exp_t;

  logic             ck = 1'b0;
  logic             rst = 1'b1;
  logic [18:0]      mask_in = '0;
  logic             start = 1'b0;
  logic [15:0]      len_in = '0;
  logic [31:0]      exp_in = '0;
  logic             in_valid = 1'b0;
  logic [18:0]      in_data = '0;
  logic             in_ready, busy, done, pass;
  logic [31:0]      sig;
  logic [15:0]      count;

  int   checks = 0;
  int   errors = 0;
  bit   armed  = 1'b0;
  exp_t sb[$];

  always #5 ck = ~ck;

  resp_compactor #(
    .WIDTH (WIDTH), .SIG_W (SIG_W), .CNT_W (CNT_W), .POLY (POLY), .SEED (SEED)
  ) dut (
    .ck       (ck),
    .rst      (rst),
`ifdef RESP_COMPACTOR_MASK_EN
    .mask     (mask_in),
`endif
    .start    (start),
    .len      (len_in),
    .exp_sig  (exp_in),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .sig      (sig),
    .count    (count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Software MISR: fold each masked vector into the signature in order.
  function automatic logic [31:0] model_sig(input logic [18:0] v[$], input logic [18:0] m);
    logic [31:0] s;
    logic [31:0] d;
    s = SEED;
    foreach (v[i]) begin
      d = 32'(v[i] & ~m);
      s = (s << 1) ^ (s[31] ? POLY : 32'h0) ^ d;
    end
    return s;
  endfunction

  // Monitor: on the first DONE cycle of an armed run, pop and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge ck);
      #1;
      if (armed && done) begin
        if (sb.size() == 0) begin
          check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("done_sig",   sig,             e.sig);
          check("done_count", 32'(count),      32'(e.count));
          check("done_pass",  32'(pass),       32'(e.pass));
          check("done_ready", 32'(in_ready),   32'd0);
          check("done_busy",  32'(busy),       32'd0);
        end
        armed = 1'b0;
      end
    end
  end

  // One run: start, stream vecs with random stalls, optionally poke start in
  // RUN, then keep offering data to prove nothing beyond LEN is absorbed.
  task automatic run(input logic [18:0] vecs[$], input logic [31:0] exp_v,
                     input logic [18:0] m, input bit poke_start);
    int          n;
    int          idx;
    int          cyc;
    int          limit;
    bit          poked;
    exp_t        e;
    n     = vecs.size();
    e.sig   = model_sig(vecs, m);
    e.count = 16'(n);
    e.pass  = (e.sig == exp_v);
    @(negedge ck);
    start   = 1'b1;
    len_in  = 16'(n);
    exp_in  = exp_v;
    mask_in = m;
    @(negedge ck);
    start   = 1'b0;
    mask_in = 19'(~m);   // must not matter once sampled
    sb.push_back(e);
    armed = 1'b1;
    idx = 0; cyc = 0; poked = 1'b0;
    limit = 8 * n + 40;
    while ((idx < n || armed) && cyc < limit) begin
      in_valid = ($urandom_range(0, 9) < 7);
      in_data  = (idx < n) ? vecs[idx] : 19'($urandom);
      start    = 1'b0;
      if (poke_start && !poked && idx >= 1 && idx < n) begin
        start  = 1'b1;
        len_in = 16'd7;
        exp_in = 32'hDEADBEEF;
        poked  = 1'b1;
      end
      if (in_valid && in_ready && idx < n) idx++;
      @(negedge ck);
      cyc++;
    end
    start = 1'b0;
    if (cyc >= limit) check("run_timeout", 32'(cyc), 32'(limit - 1));
    in_valid = 1'b1;
    repeat (3) begin
      in_data = 19'($urandom) | 19'h1;
      @(negedge ck);
    end
    in_valid = 1'b0;
    check("hold_sig",   sig,        e.sig);
    check("hold_count", 32'(count), 32'(n));
    check("hold_done",  32'(done),  32'd1);
  endtask

  initial begin
    logic [18:0] v[$];
    logic [31:0] s;
    logic [18:0] m;
    int          n;

    // Reset state
    #12;
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_busy",  32'(busy),     32'd0);
    check("rst_done",  32'(done),     32'd0);
    check("rst_pass",  32'(pass),     32'd0);
    check("rst_sig",   sig,           SEED);
    check("rst_count", 32'(count),    32'd0);
    @(negedge ck);
    rst = 1'b0;

    // Single vector 1 -> signature 1, pass
    v = '{19'h00001};
    run(v, 32'h00000001, 19'h0, 1'b0);
    // Two vectors 1,0 -> signature 2
    v = '{19'h00001, 19'h00000};
    run(v, 32'h00000002, 19'h0, 1'b0);
    // Wrong expected value -> pass low
    v = '{19'h00001, 19'h00000};
    run(v, 32'h00000000, 19'h0, 1'b0);
    // Empty run: straight to DONE, SIG stays SEED
    v = {};
    run(v, 32'h00001234, 19'h0, 1'b0);
    // Stalls plus start pulse while running
    v = '{19'h12345, 19'h7FFFF, 19'h00F0F};
    run(v, 32'h0, 19'h0, 1'b1);
    // Enough high-bit data to exercise the feedback path
    v = {};
    for (int i = 0; i < 20; i++) v.push_back(19'h40000);
    run(v, model_sig(v, 19'h0), 19'h0, 1'b0);
`ifdef RESP_COMPACTOR_MASK_EN
    // Fully masked: data is ignored, only shifting of SEED remains
    v = '{19'h7FFFF, 19'h12345, 19'h55555};
    run(v, SEED, 19'h7FFFF, 1'b0);
`endif

    // Reset in the middle of a 4-vector run after one beat
    @(negedge ck);
    start = 1'b1; len_in = 16'd4; exp_in = 32'h0;
    @(negedge ck);
    start = 1'b0; in_valid = 1'b1; in_data = 19'h0ABCD;
    @(negedge ck);
    in_valid = 1'b0;
    check("mid_count", 32'(count), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_ready", 32'(in_ready), 32'd0);
    check("arst_busy",  32'(busy),     32'd0);
    check("arst_done",  32'(done),     32'd0);
    check("arst_pass",  32'(pass),     32'd0);
    check("arst_sig",   sig,           SEED);
    check("arst_count", 32'(count),    32'd0);
    @(negedge ck);
    rst = 1'b0;

    // Randomized runs
    for (int r = 0; r < 30; r++) begin
      n = $urandom_range(1, 40);
      v = {};
      for (int i = 0; i < n; i++) v.push_back(19'($urandom));
`ifdef RESP_COMPACTOR_MASK_EN
      m = 19'($urandom) & 19'($urandom);
`else
      m = 19'h0;
`endif
      s = model_sig(v, m);
      if ($urandom_range(0, 1) == 1) s = s ^ (32'h1 << $urandom_range(0, 31));
      run(v, s, m, (n >= 3) && ($urandom_range(0, 3) == 0));
    end

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_resp_compactor
